add4wsplit: RTL

Decomposes a 16-bit target value into a base term plus three capped, signed contributions (c1..c3 with sign bits) and a leftover residual, in the form the signed four-term adder consumes: sum = c0 ± c1 ± c2 ± c3. It sits upstream of that adder in the anspwm datapath. A multi-cycle FSM does one greedy stage per clock, with valid/ready handshakes on both the input and output sides.

---
 rtl/anspwm_pkg.sv | 19 +
 rtl/add4wsplit_split_stage.sv | 22 ++
 rtl/add4wsplit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/anspwm_pkg.sv
// Shared types and constants for the anspwm datapath: the splitter FSM state
// encoding, the datapath width and the default magnitude caps for c1..c3.
package anspwm_pkg;

   localparam int W = 16;

   localparam int LIM1_DEF = 4096;
   localparam int LIM2_DEF = 256;
   localparam int LIM3_DEF = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S1   = 3'd1,
      S2   = 3'd2,
      S3   = 3'd3,
      DONE = 3'd4
   } split_state_t;

endpackage

// File: rtl/add4wsplit_split_stage.sv
// One greedy split step: takes as much of the signed residual as the cap
// allows and reports the magnitude, the sign (1 = subtract) and the new residual.
module split_stage
   import anspwm_pkg::*;
(
   input  logic [W-1:0] r,
   input  logic [W-1:0] lim,
   output logic [W-1:0] c,
   output logic         s,
   output logic [W-1:0] rNext
);

   logic [W:0] mag;

   // Magnitude is one bit wider so that r = -32768 yields +32768 instead of
   // wrapping back to a negative number.
   assign mag   = r[W-1] ? ((W+1)'(0) - {1'b1, r}) : {1'b0, r};
   assign c     = (mag > {1'b0, lim}) ? lim : mag[W-1:0];
   assign s     = r[W-1] & (c != '0);
   assign rNext = s ? (r + c) : (r - c);

endmodule

// File: rtl/add4wsplit.sv
// Splits a 16-bit target into c0 plus three capped signed terms and a residual,
// one greedy stage per clock. Optional build macro ADD4WSPLIT_ZERO_SKIP_EN jumps
// straight to DONE once the residual reaches zero on stage entry.
module add4wsplit
   import anspwm_pkg::*;
#(
   parameter int LIM1 = LIM1_DEF,
   parameter int LIM2 = LIM2_DEF,
   parameter int LIM3 = LIM3_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] value,
   input  logic [W-1:0] c0,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] c0_o,
   output logic [W-1:0] c1,
   output logic [W-1:0] c2,
   output logic [W-1:0] c3,
   output logic         c1s,
   output logic         c2s,
   output logic         c3s,
   output logic [W-1:0] resid
);

   split_state_t state;
   logic [W-1:0] r;
   logic [W-1:0] stageLim;
   logic [W-1:0] stageC;
   logic [W-1:0] stageRNext;
   logic         stageS;
   logic         skipRest;

   assign in_ready = (state == IDLE);

   // A single shared stage datapath; the cap it applies follows the current state.
   always_comb begin
      stageLim = W'(LIM3);
      case (state)
         S1:      stageLim = W'(LIM1);
         S2:      stageLim = W'(LIM2);
         default: stageLim = W'(LIM3);
      endcase
   end

   split_stage uStage (
      .r     (r),
      .lim   (stageLim),
      .c     (stageC),
      .s     (stageS),
      .rNext (stageRNext)
   );

`ifdef ADD4WSPLIT_ZERO_SKIP_EN
   assign skipRest = (r == '0);
`else
   assign skipRest = 1'b0;
`endif

   // Main FSM: accept in IDLE, run S1..S3 one per clock, then present the result
   // in DONE. out_valid is registered, so it rises one edge after DONE is entered
   // and everything holds until the consumer takes the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         r         <= '0;
         out_valid <= 1'b0;
         c0_o      <= '0;
         c1        <= '0;
         c2        <= '0;
         c3        <= '0;
         c1s       <= 1'b0;
         c2s       <= 1'b0;
         c3s       <= 1'b0;
         resid     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  c0_o  <= c0;
                  r     <= value - c0;
                  c1    <= '0;
                  c2    <= '0;
                  c3    <= '0;
                  c1s   <= 1'b0;
                  c2s   <= 1'b0;
                  c3s   <= 1'b0;
                  state <= S1;
               end
            end
            S1, S2, S3: begin
               if (skipRest) begin
                  state <= DONE;
               end else begin
                  r <= stageRNext;
                  case (state)
                     S1: begin
                        c1    <= stageC;
                        c1s   <= stageS;
                        state <= S2;
                     end
                     S2: begin
                        c2    <= stageC;
                        c2s   <= stageS;
                        state <= S3;
                     end
                     default: begin
                        c3    <= stageC;
                        c3s   <= stageS;
                        state <= DONE;
                     end
                  endcase
               end
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  resid     <= r;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
